// File: rtl/alu_seq_fsm.sv
// Shared arithmetic sequencer for the UM add/mul/div/nand opcodes.
// Reads b then c over the register-file port, executes, then writes a once.
//
// state   | meaning
// SEL_B   | idle; present regB, latch op/regA/regC when en rises
// SEL_C   | present regC; capture b from the read bus
// LATCH_C | capture c; single-cycle ops resolve here
// EXEC    | one divide/multiply iteration per cycle
// WRITE_A | present regA with reg_mode=1 for exactly one cycle
// FIN     | finished=1; hold until en falls
module alu_seq_fsm #(
    parameter int WIDTH    = 32,
    parameter int SEL_W    = 3,
    parameter int MUL_ITER = 0
) (
    input  logic             clk,
    input  logic             init,
    input  logic             en,
    input  logic [3:0]       op,
    input  logic [SEL_W-1:0] regA,
    input  logic [SEL_W-1:0] regB,
    input  logic [SEL_W-1:0] regC,
    input  logic [WIDTH-1:0] reg_out_bus,
    output logic [SEL_W-1:0] reg_sel,
    output logic             reg_mode,
    output logic [WIDTH-1:0] reg_data,
    output logic             finished,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;

    typedef enum logic [2:0] {SEL_B, SEL_C, LATCH_C, EXEC, WRITE_A, FIN} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [SEL_W-1:0] rega_q, rega_d, regc_q, regc_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d, result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] mul_full, mul_step, x_next, acc_next;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;

    // x doubles as dividend/quotient shifter and multiplier shifter; acc holds remainder or partial product
    always_comb begin
        mul_full = x_q * reg_out_bus;
        mul_step = (acc_q << 1) + (x_q[WIDTH-1] ? y_q : '0);
        rem_sh   = {acc_q, x_q[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, y_q});
        if (op_q == OP_DIV) begin
            x_next   = (x_q << 1) | WIDTH'(rem_ge);
            acc_next = rem_ge ? WIDTH'(rem_sh - {1'b0, y_q}) : rem_sh[WIDTH-1:0];
        end else begin
            x_next   = x_q << 1;
            acc_next = mul_step;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rega_d   = rega_q;
        regc_d   = regc_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        reg_sel  = regc_q;
        reg_mode = 1'b0;
        finished = 1'b0;

        case (state_q)
            SEL_B:   reg_sel = regB;
            WRITE_A: begin
                reg_sel  = rega_q;
                reg_mode = 1'b1;
            end
            FIN:     finished = 1'b1;
            default: ;
        endcase

        if (!en) begin
            state_d = SEL_B;
            cnt_d   = '0;
            dbz_d   = 1'b0;
        end else begin
            case (state_q)
                SEL_B: begin
                    op_d    = op;
                    rega_d  = regA;
                    regc_d  = regC;
                    state_d = SEL_C;
                end
                SEL_C: begin
                    x_d     = reg_out_bus;
                    state_d = LATCH_C;
                end
                LATCH_C: begin
                    y_d     = reg_out_bus;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = FIN;
                    case (op_q)
                        OP_ADD: begin
                            result_d = x_q + reg_out_bus;
                            state_d  = WRITE_A;
                        end
                        OP_NAND: begin
                            result_d = ~(x_q & reg_out_bus);
                            state_d  = WRITE_A;
                        end
                        OP_MUL: begin
                            if (MUL_ITER == 0) begin
                                result_d = mul_full;
                                state_d  = WRITE_A;
                            end else begin
                                state_d = EXEC;
                            end
                        end
                        OP_DIV: begin
                            if (reg_out_bus == '0) dbz_d = 1'b1;
                            else                   state_d = EXEC;
                        end
                        default: ;
                    endcase
                end
                EXEC: begin
                    x_d   = x_next;
                    acc_d = acc_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_d = (op_q == OP_DIV) ? x_next : acc_next;
                        state_d  = WRITE_A;
                    end
                end
                WRITE_A: state_d = FIN;
                FIN:     state_d = FIN;
                default: state_d = SEL_B;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q  <= SEL_B;
            op_q     <= '0;
            rega_q   <= '0;
            regc_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rega_q   <= rega_d;
            regc_q   <= regc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign reg_data    = result_q;
    assign div_by_zero = dbz_q;

endmodule
